// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (port 0)
// and the branch/compare unit (port 1); IDLE -> EXEC -> RESP per operation.
module alu_arbiter #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op1_0,
  input  logic [3:0]           req_op2_0,
  input  logic [BIT_WIDTH-1:0] req_a_0,
  input  logic [BIT_WIDTH-1:0] req_b_0,
  input  logic [3:0]           req_op1_1,
  input  logic [3:0]           req_op2_1,
  input  logic [BIT_WIDTH-1:0] req_a_1,
  input  logic [BIT_WIDTH-1:0] req_b_1,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [BIT_WIDTH-1:0] rsp_data,
  output logic [3:0]           alu_op1,
  output logic [3:0]           alu_op2,
  output logic [BIT_WIDTH-1:0] alu_a,
  output logic [BIT_WIDTH-1:0] alu_b,
  input  logic [BIT_WIDTH-1:0] alu_result,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_rr_ptr;
  logic                 r_id;
  logic [3:0]           r_op1;
  logic [3:0]           r_op2;
  logic [BIT_WIDTH-1:0] r_a;
  logic [BIT_WIDTH-1:0] r_b;
  logic [BIT_WIDTH-1:0] r_rsp_data;
  logic [1:0]           r_rsp_valid;

  logic w_any;
  logic w_gnt_id;
  logic w_accept;

  // With both ports requesting the pointer decides; otherwise the lone requester wins.
  assign w_any    = |req_valid;
  assign w_gnt_id = (&req_valid) ? r_rr_ptr : req_valid[1];
  assign w_accept = (r_state == IDLE) && !reset && w_any;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign req_ready[gi] = w_accept && (w_gnt_id == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_id        <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op1    <= w_gnt_id ? req_op1_1 : req_op1_0;
            r_op2    <= w_gnt_id ? req_op2_1 : req_op2_0;
            r_a      <= w_gnt_id ? req_a_1   : req_a_0;
            r_b      <= w_gnt_id ? req_b_1   : req_b_0;
            r_id     <= w_gnt_id;
            r_rr_ptr <= ~w_gnt_id;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data        <= alu_result;
          r_rsp_valid[r_id] <= 1'b1;
          r_state           <= RESP;
        end
        RESP: begin
          // Only the owning port's ready can retire the response.
          if (rsp_ready[r_id]) begin
            r_rsp_valid <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign alu_op1   = r_op1;
  assign alu_op2   = r_op2;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: per-port request drivers, a reference ALU on the alu_* pins,
// and a response scoreboard popped by a monitor on each response handshake.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op1_0, req_op2_0, req_op1_1, req_op2_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  alu_op1, alu_op2;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        busy;

  always #5 clk = ~clk;

  alu_arbiter #(.BIT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1_0(req_op1_0), .req_op2_0(req_op2_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_op1_1(req_op1_1), .req_op2_1(req_op2_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .busy(busy)
  );

  // Reference ALU: ADD, SUB and signed less-than.
  always_comb begin
    alu_result = 32'h0;
    case ({alu_op1, alu_op2})
      8'h00:   alu_result = alu_a + alu_b;
      8'h01:   alu_result = alu_a - alu_b;
      8'h22:   alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'h0;
    endcase
  end

  typedef struct packed {
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  req_t rq0[$];
  req_t rq1[$];
  exp_t sb[$];
  logic gport[$];
  int   gcyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_req(input int k, input logic [3:0] o1, input logic [3:0] o2,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit want_rsp, input logic [31:0] exp);
    req_t r;
    exp_t e;
    r.op1 = o1; r.op2 = o2; r.a = a; r.b = b;
    if (k == 0) rq0.push_back(r); else rq1.push_back(r);
    if (want_rsp) begin
      e.port = (k != 0);
      e.data = exp;
      sb.push_back(e);
    end
  endtask

  task automatic wait_grant(input int k);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[k] === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: port %0d got no grant, required one within 20 cycles", k);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && busy === 1'b0 && rq0.size() == 0 && rq1.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses still pending, required 0", sb.size());
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-port drivers: hold each request until it is accepted, then load the next one.
  initial begin
    logic [1:0] acc;
    req_t r;
    req_valid = 2'b00;
    req_op1_0 = '0; req_op2_0 = '0; req_a_0 = '0; req_b_0 = '0;
    req_op1_1 = '0; req_op2_1 = '0; req_a_1 = '0; req_b_1 = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0] || !req_valid[0]) begin
        if (rq0.size() > 0) begin
          r = rq0.pop_front();
          req_op1_0 = r.op1; req_op2_0 = r.op2; req_a_0 = r.a; req_b_0 = r.b;
          req_valid[0] = 1'b1;
        end else req_valid[0] = 1'b0;
      end
      if (acc[1] || !req_valid[1]) begin
        if (rq1.size() > 0) begin
          r = rq1.pop_front();
          req_op1_1 = r.op1; req_op2_1 = r.op2; req_a_1 = r.a; req_b_1 = r.b;
          req_valid[1] = 1'b1;
        end else req_valid[1] = 1'b0;
      end
    end
  end

  // Monitor: grant log plus scoreboard pop on each response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        check("req_ready_onehot", {31'd0, req_ready == 2'b11}, 32'd0);
        gport.push_back(req_ready[1]);
        gcyc.push_back(cyc);
      end
      if (rsp_valid === 2'b11) check("rsp_valid_onehot", {30'd0, rsp_valid}, 32'd1);
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid[k] === 1'b1 && rsp_ready[k] === 1'b1) begin
          $display("rsp port %0d data 0x%08h at cycle %0d", k, rsp_data, cyc);
          if (sb.size() == 0) begin
            check("unexpected_rsp_port", k, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("rsp_port", k, {31'd0, e.port});
            check("rsp_data", rsp_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_op", {24'd0, alu_op1, alu_op2}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: port0 ADD 5+7, latency check
    push_req(0, 4'h0, 4'h0, 32'd5, 32'd7, 1, 32'd12);
    wait_grant(0);
    check("t1_req_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("t1_n1_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("t1_n1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t1_n2_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("t1_n2_rsp_data", rsp_data, 32'd12);
    @(posedge clk); #1 rsp_ready = 2'b01;
    @(posedge clk); #1 rsp_ready = 2'b00;
    @(negedge clk);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // 2: port1 SUB 3-10 with a 4-cycle stall
    push_req(1, 4'h0, 4'h1, 32'd3, 32'd10, 1, 32'hFFFF_FFF9);
    wait_grant(1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", {30'd0, rsp_valid}, 32'd2);
      check("t2_hold_data", rsp_data, 32'hFFFF_FFF9);
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 2'b10;
    @(posedge clk); #1 rsp_ready = 2'b00;
    @(negedge clk);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // 3: both valid through reset, port0 ADD 1+1 then port1 LT -3<2
    @(posedge clk); #1 reset = 1'b1;
    push_req(0, 4'h0, 4'h0, 32'd1, 32'd1, 1, 32'd2);
    push_req(1, 4'h2, 4'h2, 32'hFFFF_FFFD, 32'd2, 1, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t3_rst_req_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("t3_rst_req_ready2", {30'd0, req_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b0; rsp_ready = 2'b11;
    wait_drain();

    // 4: six back-to-back ops, alternating grants every 3 cycles
    gport.delete();
    gcyc.delete();
    push_req(0, 4'h0, 4'h0, 32'd10, 32'd1, 1, 32'd11);
    push_req(1, 4'h0, 4'h1, 32'd50, 32'd8, 1, 32'd42);
    push_req(0, 4'h0, 4'h0, 32'd20, 32'd2, 1, 32'd22);
    push_req(1, 4'h0, 4'h1, 32'd9,  32'd4, 1, 32'd5);
    push_req(0, 4'h0, 4'h0, 32'd30, 32'd3, 1, 32'd33);
    push_req(1, 4'h0, 4'h1, 32'd7,  32'd7, 1, 32'd0);
    wait_drain();
    check("t4_grant_count", gport.size(), 32'd6);
    for (int i = 0; i < gport.size() && i < 6; i++) begin
      check("t4_grant_port", {31'd0, gport[i]}, i % 2);
      if (i > 0) check("t4_grant_spacing", gcyc[i] - gcyc[i-1], 32'd3);
    end

    // 5: reset during EXEC drops the op and restores rr_ptr to port 0
    push_req(0, 4'h0, 4'h0, 32'd4, 32'd4, 0, 32'd0);
    wait_grant(0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("t5_rsp_valid2", {30'd0, rsp_valid}, 32'd0);
    push_req(0, 4'h0, 4'h0, 32'd20, 32'd22, 1, 32'd42);
    push_req(1, 4'h0, 4'h0, 32'd1,  32'd2,  1, 32'd3);
    wait_drain();

    // 6: port1's rsp_ready cannot retire port0's response
    rsp_ready = 2'b10;
    push_req(0, 4'h0, 4'h1, 32'd100, 32'd1, 1, 32'd99);
    wait_grant(0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("t6_hold_valid", {30'd0, rsp_valid}, 32'd1);
      check("t6_hold_data", rsp_data, 32'd99);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 2'b11;
    @(posedge clk); #1 rsp_ready = 2'b00;
    @(negedge clk);
    check("t6_idle", {31'd0, busy}, 32'd0);
    check("t6_rsp_valid", {30'd0, rsp_valid}, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
